// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped countdown timer for the CPU data bus. A word-offset register
// file (CTRL, PRESET, COUNT, optional PRESCALE) controls a four-state countdown
// FSM. When COUNT reaches its terminal value the FSM raises int_flag. irq is
// int_flag gated by the CTRL interrupt mask.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   addr    in   2   word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=PRESCALE
//   we      in   1   write strobe, sampled on the rising clk edge
//   byteen  in   4   per-byte write enables
//   wdata   in  32   write data
//   rdata   out 32   combinational read data for addr
//   irq     out  1   interrupt request (IM & int_flag)
//
// CTRL: [0] EN, [2:1] MODE (01 = auto-reload, anything else = one-shot),
//       [3] IM. Bits [31:4] read as zero and are ignored on write.
//
// Optional build macro: TIMER_PRESCALE_EN
//   When it is defined, offset 3 becomes an 8-bit PRESCALE register, and an
//   internal divider slows COUNT steps to one every PRESCALE+1 cycles in CNT.
//   When it is undefined, offset 3 reads 0 and writes to it are ignored.
// -----------------------------------------------------------------------------
module timer_counter #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] A_CTRL     = 2'd0;
   localparam logic [1:0] A_PRESET   = 2'd1;
   localparam logic [1:0] A_COUNT    = 2'd2;
   localparam logic [1:0] A_PRESCALE = 2'd3;

   state_t           state_q, state_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             int_flag_q, int_flag_d;

   // PRESET is merged byte-by-byte in a full 32-bit view and then truncated
   // back to CNT_W.
   logic [31:0]      preset_ext;
   logic [31:0]      preset_merged;
   logic [3:0]       ctrl_merged;
   logic             step;

   assign preset_ext = 32'(preset_q);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign preset_merged[8*gi +: 8] = byteen[gi] ? wdata[8*gi +: 8]
                                                      : preset_ext[8*gi +: 8];
      end
   endgenerate

   // Only the low nibble of CTRL exists, so only byte lane 0 can change it.
   assign ctrl_merged = byteen[0] ? wdata[3:0] : ctrl_q;

`ifdef TIMER_PRESCALE_EN
   logic [7:0] prescale_q, prescale_d;
   logic [7:0] div_q, div_d;

   // COUNT moves only when the divider reaches PRESCALE. PRESCALE=0 therefore
   // steps on every CNT cycle.
   assign step = (div_q == prescale_q);
`else
   assign step = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      int_flag_d = int_flag_q;
`ifdef TIMER_PRESCALE_EN
      prescale_d = prescale_q;
      div_d      = div_q;
`endif

      // ---------------- countdown FSM ----------------
      case (state_q)
         IDLE: begin
`ifdef TIMER_PRESCALE_EN
            div_d = 8'd0;
`endif
            if (ctrl_q[0]) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
`ifdef TIMER_PRESCALE_EN
            div_d = 8'd0;
`endif
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!ctrl_q[0]) begin
               state_d = IDLE;
            end else if (step) begin
`ifdef TIMER_PRESCALE_EN
               div_d = 8'd0;
`endif
               // A COUNT of 0 is terminal as well, so PRESET=0 acts like PRESET=1.
               if (count_q > CNT_W'(1)) begin
                  count_d = count_q - CNT_W'(1);
               end else begin
                  count_d    = '0;
                  int_flag_d = 1'b1;
                  state_d    = INT;
               end
            end else begin
`ifdef TIMER_PRESCALE_EN
               div_d = div_q + 8'd1;
`endif
            end
         end
         INT: begin
            if (ctrl_q[2:1] == 2'b01) begin
               // Auto-reload: clearing the flag here makes irq a one-cycle pulse.
               int_flag_d = 1'b0;
               state_d    = LOAD;
            end else begin
               // One-shot: the timer disables itself and the flag stays set.
               ctrl_d[0] = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // ---------------- bus writes ----------------
      // These assignments come after the FSM, so a bus write to a register
      // wins over an FSM update to that register in the same cycle.
      if (we) begin
         case (addr)
            A_CTRL: begin
               ctrl_d     = ctrl_merged;
               int_flag_d = 1'b0;
            end
            A_PRESET: begin
               preset_d   = preset_merged[CNT_W-1:0];
               int_flag_d = 1'b0;
            end
            A_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
               if (byteen[0]) begin
                  prescale_d = wdata[7:0];
               end
`endif
            end
            default: begin
               // COUNT is read-only.
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= '0;
         count_q    <= '0;
         int_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         int_flag_q <= int_flag_d;
      end
   end

`ifdef TIMER_PRESCALE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale_q <= 8'd0;
         div_q      <= 8'd0;
      end else begin
         prescale_q <= prescale_d;
         div_q      <= div_d;
      end
   end
`endif

   // ---------------- read mux ----------------
   always_comb begin
      rdata = 32'd0;
      case (addr)
         A_CTRL:     rdata = {28'd0, ctrl_q};
         A_PRESET:   rdata = 32'(preset_q);
         A_COUNT:    rdata = 32'(count_q);
         A_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
            rdata = {24'd0, prescale_q};
`else
            rdata = 32'd0;
`endif
         end
         default:    rdata = 32'd0;
      endcase
   end

   // irq comes straight from flops, so an asynchronous reset drops it at once.
   assign irq = ctrl_q[3] & int_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Scoreboard bench for timer_counter. Stimulus drives inputs one time unit
// after each rising edge. Each probe sets addr, pushes the hand-computed
// expected {rdata, irq} into a queue, and signals the monitor. The monitor pops
// the entry and compares it while the DUT outputs are stable mid-cycle.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_counter #(.CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } exp_t;

    exp_t sb[$];
    event probe_ev;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_direct_fail = 0;
    bit   done = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(probe_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (rdata === e.exp_rdata && irq === e.exp_irq) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got rdata=%08h irq=%b, expected rdata=%08h irq=%b",
                             e.name, rdata, irq, e.exp_rdata, e.exp_irq);
                end
            end
        end
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete within 20000 time units");
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        @(posedge clk);
        #1;
        we     = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
    endtask

    task automatic probe(input logic [1:0] a, input logic [31:0] exp_rd,
                         input logic exp_irq, input string nm);
        addr = a;
        sb.push_back('{nm, exp_rd, exp_irq});
        #1;
        ->probe_ev;
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        addr   = 2'd0;
        we     = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        if (irq !== 1'b0 || rdata !== 32'd0) begin
            n_direct_fail++;
            $display("FAIL rst_direct: got rdata=%08h irq=%b, expected rdata=00000000 irq=0",
                     rdata, irq);
        end else begin
            $display("PASS rst_direct: rdata=%08h irq=%b", rdata, irq);
        end

        // ---------------- reset state ----------------
        probe(2'd0, 32'd0, 1'b0, "rst_ctrl");
        probe(2'd1, 32'd0, 1'b0, "rst_preset");
        probe(2'd2, 32'd0, 1'b0, "rst_count");
        probe(2'd3, 32'd0, 1'b0, "rst_off3");

        // ---------------- byte enables / ignored writes ----------------
        wr(2'd1, 32'hAABBCCDD, 4'b0011);
        probe(2'd1, 32'h0000CCDD, 1'b0, "be_preset");
        wr(2'd2, 32'h12345678, 4'b1111);
        probe(2'd2, 32'd0, 1'b0, "be_count_ro");
        wr(2'd0, 32'h0000000F, 4'b1110);
        probe(2'd0, 32'd0, 1'b0, "be_ctrl_lane0");
        wr(2'd0, 32'hFFFFFFF0, 4'b1111);
        probe(2'd0, 32'd0, 1'b0, "ctrl_upper_ign");
`ifndef TIMER_PRESCALE_EN
        wr(2'd3, 32'h000000FF, 4'b1111);
        probe(2'd3, 32'd0, 1'b0, "off3_ignored");
`endif

        // ---------------- one-shot, PRESET=5 ----------------
        wr(2'd1, 32'd5, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        for (int k = 1; k <= 7; k++) begin
            tick();
            probe(2'd2, (k < 2) ? 32'd0 : ((k < 7) ? 32'(7 - k) : 32'd0),
                  (k == 7), $sformatf("os_count_k%0d", k));
        end
        probe(2'd0, 32'h9, 1'b1, "os_ctrl_int");
        tick();
        probe(2'd0, 32'h8, 1'b1, "os_ctrl_en_clr");
        tick();
        probe(2'd2, 32'd0, 1'b1, "os_irq_hold");
        wr(2'd0, 32'h8, 4'b1111);
        probe(2'd0, 32'h8, 1'b0, "os_irq_clear");

        // ---------------- auto-reload, PRESET=3 ----------------
        wr(2'd1, 32'd3, 4'b1111);
        wr(2'd0, 32'hB, 4'b1111);
        for (int k = 1; k <= 14; k++) begin
            int p;
            p = (k - 1) % 5;
            tick();
            probe(2'd2, (p == 0 || p == 4) ? 32'd0 : 32'(4 - p), (p == 4),
                  $sformatf("ar_count_k%0d", k));
            probe(2'd0, 32'hB, (p == 4), $sformatf("ar_ctrl_k%0d", k));
        end
        tick();
        probe(2'd2, 32'd0, 1'b1, "ar_int_k15");

        // ---------------- asynchronous reset mid-cycle while irq=1 ----------------
        reset = 1'b1;
        probe(2'd0, 32'd0, 1'b0, "arst_ctrl");
        probe(2'd1, 32'd0, 1'b0, "arst_preset");
        probe(2'd2, 32'd0, 1'b0, "arst_count");
        reset = 1'b0;
        tick();

        // ---------------- PRESET=0 behaves as 1 ----------------
        wr(2'd0, 32'h9, 4'b1111);
        for (int k = 1; k <= 3; k++) begin
            tick();
            probe(2'd2, 32'd0, (k == 3), $sformatf("p0_k%0d", k));
        end
        wr(2'd0, 32'h8, 4'b1111);
        probe(2'd0, 32'h8, 1'b0, "p0_clear");

        // ---------------- PRESET=10 with a mid-count PRESET write and pause ----------------
        wr(2'd1, 32'd10, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        tick();
        tick();
        probe(2'd2, 32'd10, 1'b0, "p10_first");
        tick();
        probe(2'd2, 32'd9, 1'b0, "p10_nine");
        wr(2'd1, 32'd20, 4'b1111);
        probe(2'd2, 32'd8, 1'b0, "p20_no_effect");
        probe(2'd1, 32'd20, 1'b0, "p20_preset");
        tick();
        probe(2'd2, 32'd7, 1'b0, "p10_seven");
        wr(2'd0, 32'h8, 4'b1111);
        probe(2'd2, 32'd6, 1'b0, "pause_six");
        for (int k = 0; k < 3; k++) begin
            tick();
            probe(2'd2, 32'd6, 1'b0, $sformatf("pause_hold%0d", k));
        end
        wr(2'd0, 32'h9, 4'b1111);
        tick();
        probe(2'd2, 32'd6, 1'b0, "reen_load");
        tick();
        probe(2'd2, 32'd20, 1'b0, "reen_reload20");
        tick();
        probe(2'd2, 32'd19, 1'b0, "reen_19");

        // ---------------- CTRL write in the INT cycle wins over the EN clear ----------------
        wr(2'd0, 32'h0, 4'b1111);
        wr(2'd1, 32'd1, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        tick();
        probe(2'd2, 32'd18, 1'b0, "pri_load_stale");
        tick();
        probe(2'd2, 32'd1, 1'b0, "pri_cnt1");
        tick();
        probe(2'd2, 32'd0, 1'b1, "pri_int");
        wr(2'd0, 32'h9, 4'b1111);
        probe(2'd0, 32'h9, 1'b0, "pri_bus_wins");
        tick();
        tick();
        probe(2'd2, 32'd1, 1'b0, "pri_rerun_cnt");
        tick();
        probe(2'd2, 32'd0, 1'b1, "pri_rerun_int");
        tick();
        probe(2'd0, 32'h8, 1'b1, "pri_en_clr");

        // ---------------- IM=0 masks irq ----------------
        wr(2'd0, 32'h1, 4'b1111);
        tick();
        tick();
        tick();
        probe(2'd2, 32'd0, 1'b0, "mask_int");
        tick();
        probe(2'd0, 32'd0, 1'b0, "mask_en_clr");

`ifdef TIMER_PRESCALE_EN
        // ---------------- prescaler: PRESCALE=2, PRESET=2 ----------------
        wr(2'd3, 32'h00000002, 4'b0001);
        probe(2'd3, 32'd2, 1'b0, "ps_reg");
        wr(2'd1, 32'd2, 4'b1111);
        wr(2'd0, 32'h9, 4'b1111);
        for (int k = 1; k <= 8; k++) begin
            tick();
            probe(2'd2, (k < 2) ? 32'd0 : ((k < 5) ? 32'd2 : ((k < 8) ? 32'd1 : 32'd0)),
                  (k == 8), $sformatf("ps_k%0d", k));
        end
`endif

        #2;
        done = 1'b1;
        if (n_pass != n_checks || n_direct_fail != 0) begin
            $display("FAIL summary: %0d/%0d checks passed, %0d direct failures",
                     n_pass, n_checks, n_direct_fail);
        end else begin
            $display("PASS summary: %0d/%0d checks passed", n_pass, n_checks);
        end
        $finish;
    end

endmodule
